// File: rtl/uart_tx_stream.sv
// uart_tx_stream: beat FIFO feeding a multi-word UART serializer.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_stream #(
   parameter int BITS_PER_WORD = 8,
   parameter int NUM_WORDS     = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int DIV_W         = 16
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [NUM_WORDS*BITS_PER_WORD-1:0]   s_data,
   input  logic [DIV_W-1:0]                     clk_div,
   input  logic                                 two_stop,
   input  logic                                 parity_odd,
   output logic                                 tx,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_count
);

   localparam int BEAT_W = NUM_WORDS * BITS_PER_WORD;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int BW     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
   localparam int WW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);
   localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   logic [BEAT_W-1:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]            wptr_q, wptr_d;
   logic [AW-1:0]            rptr_q, rptr_d;
   logic [CW-1:0]            count_q, count_d;
   state_t                   state_q, state_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic [DIV_W-1:0]         cnt_q, cnt_d;
   logic [DIV_W-1:0]         per_m1;
   logic [BW-1:0]            bit_q, bit_d;
   logic [WW-1:0]            word_q, word_d;
   logic                     two_q, two_d;
   logic                     stop_q, stop_d;
   logic                     push, pop, bit_end;
   logic [BITS_PER_WORD-1:0] word0;
`ifdef UART_TX_PARITY_EN
   logic                     podd_q, podd_d;
`else
   logic                     unused_parity;
   assign unused_parity = parity_odd;
`endif

   assign s_ready    = count_q < DEPTH;
   assign fifo_count = count_q;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);
   assign push       = s_valid && s_ready;
   assign pop        = (state_q == S_IDLE) && (count_q != '0);
   // a divisor below 2 still gives a 2-clock bit
   assign per_m1     = (div_q < DIV_W'(2)) ? DIV_W'(1)
                                           : div_q - DIV_W'(1);
   assign bit_end    = cnt_q == per_m1;
   assign word0      = beat_q[BITS_PER_WORD-1:0];

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= s_data;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      state_d = state_q;
      beat_d  = beat_q;
      div_d   = div_q;
      two_d   = two_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      word_d  = word_q;
      stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
      podd_d  = podd_q;
`endif
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (state_q != S_IDLE)
         cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               beat_d  = mem_q[rptr_q];
               div_d   = clk_div;
               two_d   = two_stop;
`ifdef UART_TX_PARITY_EN
               podd_d  = parity_odd;
`endif
               cnt_d   = '0;
               word_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                  stop_d  = 1'b0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (two_q && !stop_q) begin
                  stop_d = 1'b1;
               end else if (word_q == LAST_WORD) begin
                  state_d = S_IDLE;
               end else begin
                  word_d  = word_q + WW'(1);
                  beat_d  = beat_q >> BITS_PER_WORD;
                  state_d = S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         S_START:  tx = 1'b0;
         S_DATA:   tx = word0[bit_q];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx = ^word0 ^ podd_q;
`endif
         default:  tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= S_IDLE;
         beat_q  <= '0;
         div_q   <= '0;
         two_q   <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         podd_q  <= 1'b0;
`endif
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         state_q <= state_d;
         beat_q  <= beat_d;
         div_q   <= div_d;
         two_q   <= two_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         stop_q  <= stop_d;
`ifdef UART_TX_PARITY_EN
         podd_q  <= podd_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: random and directed beats, frames checked by a
// sampling receiver against a queue of expected words.
module tb_uart_tx_stream;

   localparam int BPW    = 8;
   localparam int NW     = 3;
   localparam int DEPTH  = 4;
   localparam int DIV_W  = 16;
   localparam int BEAT_W = BPW * NW;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   typedef struct {
      logic [BPW-1:0] w;
      int             p;
      int             nstop;
      bit             par;
      bit             last;
   } exp_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [BEAT_W-1:0] s_data = '0;
   logic [DIV_W-1:0]  clk_div = 16'd4;
   logic              two_stop = 1'b0;
   logic              parity_odd = 1'b0;
   logic              tx;
   logic              busy;
   logic [$clog2(DEPTH):0] fifo_count;

   int   nvec = 0;
   int   nmis = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   bit   in_frame = 1'b0;
   exp_t q[$];

   uart_tx_stream #(
      .BITS_PER_WORD(BPW),
      .NUM_WORDS(NW),
      .FIFO_DEPTH(DEPTH),
      .DIV_W(DIV_W)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .clk_div(clk_div),
      .two_stop(two_stop),
      .parity_odd(parity_odd),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int need);
      nvec++;
      if (act !== need) begin
         nmis++;
         $display("FAIL %s: got %0d need %0d", nm, act, need);
      end
   endtask

   // expected words are queued with the configuration seen at acceptance;
   // configuration only changes while the DUT is idle
   task automatic push(input logic [BEAT_W-1:0] d);
      exp_t e;
      bit   acc = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int n = 0; n < 10000 && !acc; n++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
      end
      #1 s_valid = 1'b0;
      if (!acc) begin
         nvec++;
         nmis++;
         $display("FAIL push_timeout: s_ready=0 need 1");
         return;
      end
      acc_cyc = cyc;
      for (int k = 0; k < NW; k++) begin
         e.w     = d[k*BPW +: BPW];
         e.p     = (clk_div < 2) ? 2 : int'(clk_div);
         e.nstop = two_stop ? 2 : 1;
         e.par   = (^e.w) ^ parity_odd;
         e.last  = (k == NW - 1);
         q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || q.size() != 0 || in_frame) && n < 40000);
      repeat (2) @(negedge clk);
      if (n >= 40000) begin
         nvec++;
         nmis++;
         $display("FAIL idle_timeout: busy=%b queued=%0d", busy, q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic busy_len(input string nm, input int start, input int need);
      int n = 0;
      while (busy && n < 50000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, cyc - start, need);
   endtask

   function automatic int frame_bits(input bit two);
      return 1 + BPW + PB + (two ? 2 : 1);
   endfunction

   initial begin : mon
      exp_t e;
      bit   eb[$];
      bit   ok, ab, b2b;
      int   bad_i;
      logic bad_v;
      b2b = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            b2b = 1'b0;
            continue;
         end
         if (b2b) begin
            b2b = 1'b0;
            nvec++;
            if (tx !== 1'b0) begin
               nmis++;
               $display("FAIL b2b_start: tx=%b need 0", tx);
               continue;
            end
         end else if (tx !== 1'b0) begin
            continue;
         end
         if (q.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL spurious_start: tx=0 need 1 (nothing queued)");
            while (rstn && tx === 1'b0) @(negedge clk);
            continue;
         end
         e = q.pop_front();
         in_frame = 1'b1;
         eb.delete();
         eb.push_back(1'b0);
         for (int i = 0; i < BPW; i++) eb.push_back(e.w[i]);
         if (PB != 0) eb.push_back(e.par);
         for (int i = 0; i < e.nstop; i++) eb.push_back(1'b1);
         ok = 1'b1;
         ab = 1'b0;
         bad_i = 0;
         bad_v = 1'b0;
         for (int i = 0; i < eb.size() && !ab; i++) begin
            for (int s = 0; s < e.p && !ab; s++) begin
               if (i == 0 && s == 0) continue;
               @(negedge clk);
               if (!rstn) ab = 1'b1;
               else if (tx !== eb[i] && ok) begin
                  ok = 1'b0;
                  bad_i = i;
                  bad_v = tx;
               end
            end
         end
         if (ab) begin
            in_frame = 1'b0;
            continue;
         end
         nvec++;
         if (!ok) begin
            nmis++;
            $display("FAIL frame: word %h bit %0d tx=%b need %b",
                     e.w, bad_i, bad_v, eb[bad_i]);
         end
         if (e.last) begin
            @(negedge clk);
            if (rstn) begin
               nvec++;
               if (tx !== 1'b1) begin
                  nmis++;
                  $display("FAIL idle_gap: tx=%b need 1", tx);
               end
            end
         end else begin
            b2b = 1'b1;
         end
         in_frame = 1'b0;
      end
   end

   initial begin : stim
      int t0, fb, bad, nb;
      #3 rstn = 1'b0;
      #10;
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(s_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(fifo_count), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      clk_div = 16'd4;
      two_stop = 1'b0;
      fb = frame_bits(1'b0);
      push(24'hC3A50F);
      busy_len("single_beat_len", acc_cyc, 1 + NW * fb * 4);
      wait_idle();

      clk_div = 16'd1;
      two_stop = 1'b1;
      fb = frame_bits(1'b1);
      push(BEAT_W'($urandom));
      busy_len("div1_two_stop_len", acc_cyc, 1 + NW * fb * 2);
      wait_idle();

      clk_div = 16'd2;
      two_stop = 1'b0;
      fb = frame_bits(1'b0);
      push(BEAT_W'($urandom));
      t0 = acc_cyc;
      push(BEAT_W'($urandom));
      busy_len("two_beat_gap_len", t0, 2 * NW * fb * 2 + 2);
      wait_idle();

      push(BEAT_W'($urandom));
      push(BEAT_W'($urandom));
      push(BEAT_W'($urandom));
      @(negedge clk);
      chk("pre_pushpop_count", int'(fifo_count), 2);
      @(posedge clk);
      #1;
      repeat (NW * fb * 2 - 2) @(posedge clk);
      #1;
      push(BEAT_W'($urandom));
      chk("pushpop_count", int'(fifo_count), 2);
      wait_idle();

      clk_div = 16'd100;
      for (int b = 0; b < 5; b++) push(BEAT_W'($urandom));
      @(negedge clk);
      chk("full_count", int'(fifo_count), 4);
      chk("full_ready", int'(s_ready), 0);
      push(BEAT_W'($urandom));
      chk("after_full_count", int'(fifo_count), 4);
      wait_idle();

`ifdef UART_TX_PARITY_EN
      clk_div = 16'd3;
      parity_odd = 1'b0;
      push({16'($urandom), 8'h07});
      wait_idle();
      parity_odd = 1'b1;
      push({16'($urandom), 8'h07});
      wait_idle();
`endif

      for (int it = 0; it < 6; it++) begin
         clk_div = DIV_W'($urandom_range(0, 5));
         two_stop = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) begin
            push(BEAT_W'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         wait_idle();
      end

      clk_div = 16'd4;
      two_stop = 1'b0;
      parity_odd = 1'b0;
      fb = frame_bits(1'b0);
      push(BEAT_W'($urandom));
      push(BEAT_W'($urandom));
      repeat (fb * 4 + 17) @(posedge clk);
      #2 rstn = 1'b0;
      q.delete();
      #1;
      chk("midrst_tx", int'(tx), 1);
      chk("midrst_count", int'(fifo_count), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_ready", int'(s_ready), 1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("quiet_after_reset", bad, 0);
      @(posedge clk);
      #1;
      push(BEAT_W'($urandom));
      wait_idle();

      chk("scoreboard_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
